// File: rtl/sc_pkg.sv
// Shared constants, state encoding and frame field map for the slow-control receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sc_pkg;

  // Frame geometry and abort threshold defaults.
  localparam int FRAME_LEN   = 829;
  localparam int TIMEOUT_CYC = 1024;
  localparam int CNT_W       = 10;

  // Receiver state encoding, visible on state_out.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // Field positions inside a completed frame (bit 0 = first bit received).
  localparam int DAC2_LSB    = 3;
  localparam int DAC2_MSB    = 12;
  localparam int DAC1_LSB    = 13;
  localparam int DAC1_MSB    = 22;
  localparam int MASK_OR_LSB = 27;
  localparam int MASK_OR_MSB = 154;
  localparam int GAIN_LSB    = 189;
  localparam int GAIN_MSB    = 764;
  localparam int CTEST_LSB   = 765;
  localparam int CTEST_MSB   = 828;

  // Saturating increment: the bit counter sticks at the frame length.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sc_sync_edge.sv
// Synchronizes CK_SC, D_SC and RSTn_SC into clk_in and flags CK_SC rising edges.
// Latency: 2 cycles input-to-sync, edge flag coincident with the synchronized rise.
// Backpressure: none; a free-running sampler with no handshake.
module sc_sync_edge (
  input  logic clk_in,
  input  logic resetn_in,
  input  logic ck_async_in,
  input  logic d_async_in,
  input  logic rstn_async_in,
  output logic ck_rise_out,
  output logic d_sync_out,
  output logic rstn_sync_out
);

  // Bit [0] is the metastability stage, bit [1] the usable synchronized value.
  logic [1:0] ck_sync_q, ck_sync_d;
  logic [1:0] d_sync_q, d_sync_d;
  logic [1:0] rstn_sync_q, rstn_sync_d;
  logic       ck_prev_q, ck_prev_d;

  // Shift each async input one stage along its chain; remember last synced clock.
  always_comb begin
    ck_sync_d   = {ck_sync_q[0], ck_async_in};
    d_sync_d    = {d_sync_q[0], d_async_in};
    rstn_sync_d = {rstn_sync_q[0], rstn_async_in};
    ck_prev_d   = ck_sync_q[1];
  end

  // Synchronizer flops; all cleared by the system reset.
  always_ff @(posedge clk_in) begin
    if (!resetn_in) begin
      ck_sync_q   <= '0;
      d_sync_q    <= '0;
      rstn_sync_q <= '0;
      ck_prev_q   <= 1'b0;
    end else begin
      ck_sync_q   <= ck_sync_d;
      d_sync_q    <= d_sync_d;
      rstn_sync_q <= rstn_sync_d;
      ck_prev_q   <= ck_prev_d;
    end
  end

  // D passes through the same depth as CK, so the data seen with the edge flag
  // is the value that was present when CK_SC rose.
  assign ck_rise_out   = ck_sync_q[1] & ~ck_prev_q;
  assign d_sync_out    = d_sync_q[1];
  assign rstn_sync_out = rstn_sync_q[1];

endmodule

// File: rtl/sc_receiver.sv
// Slow-control serial receiver: assembles FRAME_LEN bits, compares against a reference.
// Latency: frame_valid_out pulses 1 cycle after the synchronized final CK_SC edge.
// Backpressure: none; the transmitter must pulse RSTn_SC before the next frame.
module sc_receiver #(
  parameter int FRAME_LEN   = sc_pkg::FRAME_LEN,
  parameter int TIMEOUT_CYC = sc_pkg::TIMEOUT_CYC
) (
  input  logic                 clk_in,
  input  logic                 resetn_in,
  input  logic                 D_SC_in,
  input  logic                 CK_SC_in,
  input  logic                 RSTn_SC_in,
  input  logic [FRAME_LEN-1:0] expected_in,
  output logic [FRAME_LEN-1:0] frame_out,
  output logic                 frame_valid_out,
  output logic                 match_out,
  output logic [9:0]           bit_cnt_out,
  output logic                 err_overrun_out,
  output logic                 err_timeout_out,
  output logic [1:0]           state_out
);
  import sc_pkg::*;

  // Idle counter must be able to hold TIMEOUT_CYC itself.
  localparam int              IDLE_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_LIM = IDLE_W'(TIMEOUT_CYC);
  // The 10-bit counter limits FRAME_LEN to 1023.
  localparam logic [9:0]      FRAME_LIM   = 10'(FRAME_LEN);

  logic ck_rise;
  logic d_s;
  logic rstn_s;

  sc_sync_edge u_sync (
    .clk_in        (clk_in),
    .resetn_in     (resetn_in),
    .ck_async_in   (CK_SC_in),
    .d_async_in    (D_SC_in),
    .rstn_async_in (RSTn_SC_in),
    .ck_rise_out   (ck_rise),
    .d_sync_out    (d_s),
    .rstn_sync_out (rstn_s)
  );

  state_e               state_q, state_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [9:0]           cnt_q, cnt_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 ovr_q, ovr_d;
  logic                 to_q, to_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic                 match_q, match_d;
  logic                 valid_q, valid_d;
  logic                 take_bit;
  logic [IDLE_W-1:0]    idle_inc;

  // Next-state, shift and completion logic; transmitter reset outranks any edge.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    ovr_d    = ovr_q;
    to_d     = to_q;
    frame_d  = frame_q;
    match_d  = match_q;
    valid_d  = 1'b0;
    take_bit = 1'b0;
    idle_inc = idle_q + {{(IDLE_W-1){1'b0}}, 1'b1};

    if (!rstn_s) begin
      // Frame reset drops the partial frame and errors but keeps the last
      // completed frame and its match result visible.
      state_d = ST_IDLE;
      shift_d = '0;
      cnt_d   = '0;
      idle_d  = '0;
      ovr_d   = 1'b0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ck_rise) take_bit = 1'b1;
        end
        ST_SHIFT: begin
          if (ck_rise) begin
            take_bit = 1'b1;
          end else if (idle_inc == TIMEOUT_LIM) begin
            // Transmitter stalled mid-frame: abort and hold the error.
            state_d = ST_ERROR;
            to_d    = 1'b1;
            idle_d  = idle_inc;
          end else begin
            idle_d = idle_inc;
          end
        end
        ST_DONE: begin
          // Any bit after a full frame means the sender overran the frame.
          if (ck_rise) begin
            state_d = ST_ERROR;
            ovr_d   = 1'b1;
          end
        end
        default: begin
          // ST_ERROR: edges are ignored until a frame or system reset.
        end
      endcase

      if (take_bit) begin
        // LSB-first assembly: after FRAME_LEN shifts the first bit sits at [0].
        shift_d = {d_s, shift_q[FRAME_LEN-1:1]};
        cnt_d   = sat_inc(cnt_q, FRAME_LIM);
        idle_d  = '0;
        if (cnt_d == FRAME_LIM) begin
          state_d = ST_DONE;
          frame_d = shift_d;
          match_d = (shift_d == expected_in);
          valid_d = 1'b1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
    end
  end

  // State and datapath registers; system reset clears everything.
  always_ff @(posedge clk_in) begin
    if (!resetn_in) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
      frame_q <= '0;
      match_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
      frame_q <= frame_d;
      match_q <= match_d;
      valid_q <= valid_d;
    end
  end

  assign frame_out       = frame_q;
  assign frame_valid_out = valid_q;
  assign match_out       = match_q;
  assign bit_cnt_out     = cnt_q;
  assign err_overrun_out = ovr_q;
  assign err_timeout_out = to_q;
  assign state_out       = state_q;

endmodule

// File: tb/tb_sc_receiver.sv
`timescale 1ns/1ps
module tb_sc_receiver;

  localparam int FL = 829;

  logic          clk_in = 1'b0;
  logic          resetn_in;
  logic          D_SC_in;
  logic          CK_SC_in;
  logic          RSTn_SC_in;
  logic [FL-1:0] expected_in;
  logic [FL-1:0] frame_out;
  logic          frame_valid_out;
  logic          match_out;
  logic [9:0]    bit_cnt_out;
  logic          err_overrun_out;
  logic          err_timeout_out;
  logic [1:0]    state_out;

  sc_receiver dut (
    .clk_in          (clk_in),
    .resetn_in       (resetn_in),
    .D_SC_in         (D_SC_in),
    .CK_SC_in        (CK_SC_in),
    .RSTn_SC_in      (RSTn_SC_in),
    .expected_in     (expected_in),
    .frame_out       (frame_out),
    .frame_valid_out (frame_valid_out),
    .match_out       (match_out),
    .bit_cnt_out     (bit_cnt_out),
    .err_overrun_out (err_overrun_out),
    .err_timeout_out (err_timeout_out),
    .state_out       (state_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;

  typedef struct packed {
    logic [FL-1:0] frame;
    logic          match;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int         n_pre;      // junk bits sent before a mid-frame RSTn_SC pulse
    int         n_extra;    // bits sent after the full frame
    int         flip;       // expected_in bit to invert, -1 for none
    logic       exp_match;
    logic [1:0] exp_state;
    logic       exp_ovr;
    int         exp_valids;
  } row_t;
  row_t rows[4];

  logic [FL-1:0] fr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_frame(input string nm, input logic [FL-1:0] act, input logic [FL-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < FL; i++) begin
        if (act[i] !== exp[i]) begin
          $display("FAIL %s: first diff at bit %0d, got %b, want %b", nm, i, act[i], exp[i]);
          break;
        end
      end
    end
  endtask

  // Scoreboard: each frame_valid pulse must match the oldest pending expectation.
  always @(negedge clk_in) begin
    if (frame_valid_out === 1'b1) begin
      valid_cnt++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_valid: got pulse, want none (queue empty)");
      end else begin
        sb_t it;
        it = sb_q.pop_front();
        chk_frame("sb_frame", frame_out, it.frame);
        chk("sb_match", 32'(match_out), 32'(it.match));
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_in);
    D_SC_in = b;
    repeat (2) @(negedge clk_in);
    CK_SC_in = 1'b1;
    repeat (3) @(negedge clk_in);
    CK_SC_in = 1'b0;
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)));
  endtask

  task automatic send_frame(input logic [FL-1:0] f);
    for (int i = 0; i < FL; i++) send_bit(f[i]);
  endtask

  task automatic sc_rst();
    @(negedge clk_in);
    RSTn_SC_in = 1'b0;
    repeat (5) @(negedge clk_in);
    RSTn_SC_in = 1'b1;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic new_frame();
    for (int i = 0; i < FL; i++) fr[i] = 1'($urandom_range(1, 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frame_nz"}, 32'(frame_out != '0), 32'd0);
    chk({tag, "_valid"},    32'(frame_valid_out), 32'd0);
    chk({tag, "_match"},    32'(match_out),       32'd0);
    chk({tag, "_bitcnt"},   32'(bit_cnt_out),     32'd0);
    chk({tag, "_ovr"},      32'(err_overrun_out), 32'd0);
    chk({tag, "_to"},       32'(err_timeout_out), 32'd0);
    chk({tag, "_state"},    32'(state_out),       32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  v0;
    logic m_keep;
    sb_t it;

    rows[0] = '{n_pre: 0,   n_extra: 0, flip: -1,  exp_match: 1'b1, exp_state: 2'd2, exp_ovr: 1'b0, exp_valids: 1};
    rows[1] = '{n_pre: 0,   n_extra: 0, flip: 500, exp_match: 1'b0, exp_state: 2'd2, exp_ovr: 1'b0, exp_valids: 1};
    rows[2] = '{n_pre: 0,   n_extra: 1, flip: -1,  exp_match: 1'b1, exp_state: 2'd3, exp_ovr: 1'b1, exp_valids: 1};
    rows[3] = '{n_pre: 300, n_extra: 0, flip: -1,  exp_match: 1'b1, exp_state: 2'd2, exp_ovr: 1'b0, exp_valids: 1};

    resetn_in   = 1'b0;
    D_SC_in     = 1'b0;
    CK_SC_in    = 1'b0;
    RSTn_SC_in  = 1'b1;
    expected_in = '0;
    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    resetn_in = 1'b1;
    repeat (6) @(negedge clk_in);

    for (int r = 0; r < 4; r++) begin
      new_frame();
      expected_in = fr;
      if (rows[r].flip >= 0) expected_in[rows[r].flip] = ~fr[rows[r].flip];
      it.frame = fr;
      it.match = rows[r].exp_match;
      sb_q.push_back(it);
      v0 = valid_cnt;
      if (rows[r].n_pre > 0) begin
        send_rand(rows[r].n_pre);
        chk($sformatf("row%0d_pre_cnt", r), 32'(bit_cnt_out), 32'(rows[r].n_pre));
        sc_rst();
        chk($sformatf("row%0d_rst_cnt", r), 32'(bit_cnt_out), 32'd0);
        chk($sformatf("row%0d_rst_state", r), 32'(state_out), 32'd0);
      end
      send_frame(fr);
      send_rand(rows[r].n_extra);
      repeat (6) @(negedge clk_in);
      chk($sformatf("row%0d_state", r),  32'(state_out),       32'(rows[r].exp_state));
      chk($sformatf("row%0d_ovr", r),    32'(err_overrun_out), 32'(rows[r].exp_ovr));
      chk($sformatf("row%0d_to", r),     32'(err_timeout_out), 32'd0);
      chk($sformatf("row%0d_valids", r), 32'(valid_cnt - v0),  32'(rows[r].exp_valids));
      chk($sformatf("row%0d_cnt", r),    32'(bit_cnt_out),     32'(FL));
      chk_frame($sformatf("row%0d_frame", r), frame_out, fr);
      chk($sformatf("row%0d_match", r),  32'(match_out),       32'(rows[r].exp_match));
      // Frame reset returns to IDLE but keeps the completed frame and match.
      sc_rst();
      chk($sformatf("row%0d_post_state", r), 32'(state_out),       32'd0);
      chk($sformatf("row%0d_post_cnt", r),   32'(bit_cnt_out),     32'd0);
      chk($sformatf("row%0d_post_ovr", r),   32'(err_overrun_out), 32'd0);
      chk_frame($sformatf("row%0d_post_frame", r), frame_out, fr);
      chk($sformatf("row%0d_post_match", r), 32'(match_out), 32'(rows[r].exp_match));
    end

    // Timeout: 400 bits then silence; no frame may be reported.
    v0 = valid_cnt;
    m_keep = match_out;
    send_rand(400);
    chk("to_cnt_400", 32'(bit_cnt_out), 32'd400);
    chk("to_state_shift", 32'(state_out), 32'd1);
    repeat (1100) @(negedge clk_in);
    chk("to_flag", 32'(err_timeout_out), 32'd1);
    chk("to_state", 32'(state_out), 32'd3);
    chk("to_no_valid", 32'(valid_cnt - v0), 32'd0);
    // ERROR ignores further edges.
    send_rand(3);
    repeat (6) @(negedge clk_in);
    chk("to_err_sticky_state", 32'(state_out), 32'd3);
    chk("to_err_sticky_flag", 32'(err_timeout_out), 32'd1);
    chk_frame("to_frame_kept", frame_out, fr);
    chk("to_match_kept", 32'(match_out), 32'(m_keep));
    sc_rst();
    chk("to_clr_flag", 32'(err_timeout_out), 32'd0);
    chk("to_clr_state", 32'(state_out), 32'd0);

    // System reset mid-frame, then a clean frame.
    send_rand(200);
    @(negedge clk_in);
    resetn_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk_all_zero("midrst");
    resetn_in = 1'b1;
    repeat (6) @(negedge clk_in);
    new_frame();
    expected_in = fr;
    it.frame = fr;
    it.match = 1'b1;
    sb_q.push_back(it);
    v0 = valid_cnt;
    send_frame(fr);
    repeat (6) @(negedge clk_in);
    chk("midrst_valids", 32'(valid_cnt - v0), 32'd1);
    chk("midrst_state", 32'(state_out), 32'd2);
    chk("midrst_match", 32'(match_out), 32'd1);
    chk_frame("midrst_frame", frame_out, fr);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_receiver.md
SC_RECEIVER -- requirements
Module: sc_receiver

Interface
REQ-001 Parameter FRAME_LEN, default 829, number of slow-control bits per frame.
REQ-002 Parameter TIMEOUT_CYC, default 1024, clk_in cycles without a CK_SC rising edge before a partial frame is aborted.
REQ-003 clk_in  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 resetn_in  in  1  synchronous, active-low reset.
REQ-005 D_SC_in  in  1  serial slow-control data.
REQ-006 CK_SC_in  in  1  serial clock, asynchronous to clk_in, period ≥ 4 clk_in cycles.
REQ-007 RSTn_SC_in  in  1  active-low frame reset from the transmitter.
REQ-008 expected_in  in  FRAME_LEN  reference frame for comparison.
REQ-009 frame_out  out  FRAME_LEN  last completed frame; bit i = i-th bit received.
REQ-010 frame_valid_out  out  1  one-cycle pulse on frame completion.
REQ-011 match_out  out  1  frame_out == expected_in, latched at completion.
REQ-012 bit_cnt_out  out  10  bits received in the current frame.
REQ-013 err_overrun_out / err_timeout_out  out  1 each  sticky error flags.
REQ-014 state_out  out  2  IDLE=0, SHIFT=1, DONE=2, ERROR=3.

Function
REQ-015 CK_SC_in, D_SC_in and RSTn_SC_in SHALL each pass through a 2-flop synchronizer; the CK_SC rising edge SHALL be detected on the synchronized copy (sync=1, previous=0), with D_SC sampled from its synchronized copy in the same cycle.
REQ-016 On each detected edge in IDLE or SHIFT, shift_reg SHALL load {d, shift_reg[FRAME_LEN-1:1]} and bit_cnt SHALL increment by 1, so the first bit received ends in shift_reg[0].
REQ-017 IDLE->SHIFT on the first edge; that edge's bit SHALL be captured.
REQ-018 In SHIFT, when the edge producing bit_cnt==FRAME_LEN occurs, the block SHALL enter DONE the next cycle and perform the REQ-019 updates.
REQ-019 On the DONE transition: frame_out <= completed shift_reg; match_out <= (completed shift_reg == expected_in); frame_valid_out = 1 for exactly one cycle.
REQ-020 In DONE, any further edge before RSTn_SC low SHALL move to ERROR and set err_overrun_out; frame_out SHALL be unchanged.
REQ-021 In SHIFT, an idle counter SHALL be cleared by each edge; reaching TIMEOUT_CYC SHALL move to ERROR and set err_timeout_out.
REQ-022 ERROR SHALL ignore edges and exit only via RSTn_SC low or resetn_in.
REQ-023 Synchronized RSTn_SC low in any state SHALL clear shift_reg, bit_cnt, the idle counter and both error flags, and force IDLE.
REQ-024 If RSTn_SC low and an edge occur in the same cycle, the reset SHALL win and the edge SHALL be discarded.
REQ-025 RSTn_SC low SHALL NOT alter frame_out or match_out.
REQ-026 bit_cnt SHALL saturate at FRAME_LEN and never wrap.

Reset
REQ-027 With resetn_in low at a clk_in edge, all outputs, shift_reg, counters and synchronizers SHALL be 0 and the state SHALL be IDLE; a reset mid-frame SHALL discard the partial frame.

Structure
REQ-028 A shared package sc_pkg SHALL hold FRAME_LEN, the state encoding and the field offsets (DAC2 at 12:3, DAC1 at 22:13, mask_OR at 154:27, GAIN at 764:189, Ctest at 828:765).
REQ-029 A sub-module sc_sync_edge SHALL implement the synchronizers and the edge detector.

Verification
REQ-030 829 random bits, expected_in equal to them -> one frame_valid pulse, match_out=1, frame_out[0] = first bit, state 2.
REQ-031 Same stimulus with expected_in bit 500 flipped -> match_out=0, frame_out still equal to the sent bits.
REQ-032 830 edges without RSTn_SC -> err_overrun_out=1, state 3, frame_out holds the first 829 bits.
REQ-033 400 edges, then CK_SC idle for 1024 clk_in cycles -> err_timeout_out=1, state 3, no frame_valid pulse.
REQ-034 RSTn_SC pulsed low at bit 300, then a full 829-bit frame -> a single valid frame holding only the post-reset bits.
REQ-035 resetn_in low for 2 cycles mid-frame -> all outputs 0, state 0; the next full frame is received correctly.
